// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, reset/NOP/halt encodings,
// opcode field bounds and the fetch FSM state encoding.
package cpu_pkg;

    localparam int          PC_WIDTH  = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSN  = 32'h0000_0000;
    localparam logic [31:0] HALT_INSN = 32'hFFFF_FFFF;

    // Opcode field bounds within an instruction word
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 27;

    // FILL: waiting for first valid data after reset/redirect
    // RUN: streaming instructions
    // HALTED: fetch frozen on a halt instruction
    typedef enum logic [1:0] {
        FETCH_FILL   = 2'd0,
        FETCH_RUN    = 2'd1,
        FETCH_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_reg.sv
// Generic 32-bit enable register with asynchronous active-high clear.
// Used for the fetch PC and the in-flight PC.
module fetch_stage_reg #(
    parameter logic [31:0] RST_VAL = 32'h0
) (
    output logic [31:0] q,
    input  logic [31:0] d,
    input  logic        clk,
    input  logic        en,
    input  logic        clr
);

    // Load d when enabled; clear to RST_VAL asynchronously
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a synchronous instruction
// memory (1-cycle address->data) and feeds the F/D pipeline latch.
// Handles stall with address replay, redirect with wrong-path squash and
// the one-cycle fill bubble after reset/redirect.
// Optional feature: define FETCH_HALT_EN to stop fetch on HALT_INSN.
//
// Handshake: the F/D latch loads whenever fd_en is high; the transferred
// instruction is live only when fd_valid is also high. fd_en = ~stall |
// redirect_valid, so a redirect always loads (a NOP) to flush the latch.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_data,
    output logic [PC_WIDTH-1:0]   fd_pc,
    output logic [31:0]           fd_ir,
    output logic                  fd_valid,
    output logic                  fd_en,
    output logic                  halted,
    output logic [1:0]            dbg_state
);

    fetch_state_e          state_q;
    logic                  vld_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [PC_WIDTH-1:0]   pc_d;
    logic [PC_WIDTH-1:0]   infl_q;
    logic [PC_WIDTH-1:0]   infl_d;
    logic                  pc_en;
    logic                  advance;
    logic                  halt_hit;
    logic                  in_halt;
    logic [PC_WIDTH-1:0]   addr_sel;

    assign in_halt = (state_q == FETCH_HALTED);

    // Normal forward progress: no redirect, not stalled, not halted
    assign advance = ~redirect_valid & ~stall & ~in_halt;

    // Redirect loads both PCs with the target; advance shifts pc into infl
    assign pc_en  = redirect_valid | advance;
    assign pc_d   = redirect_valid ? redirect_pc : (pc_q + 1'b1);
    assign infl_d = redirect_valid ? redirect_pc : pc_q;

    fetch_stage_reg #(.RST_VAL(RESET_PC)) u_pc_reg (
        .q   (pc_q),
        .d   (pc_d),
        .clk (clk),
        .en  (pc_en),
        .clr (clr)
    );

    fetch_stage_reg #(.RST_VAL(RESET_PC)) u_infl_reg (
        .q   (infl_q),
        .d   (infl_d),
        .clk (clk),
        .en  (pc_en),
        .clr (clr)
    );

    // During a stall, re-present the in-flight address so imem_data keeps
    // returning the held instruction; a redirect always wins.
    assign addr_sel  = (stall & vld_q & ~redirect_valid) ? infl_q : pc_q;
    assign imem_addr = addr_sel[ADDR_WIDTH-1:0];

    assign fd_en    = ~stall | redirect_valid;
    assign fd_valid = vld_q & ~redirect_valid & ~in_halt;
    assign fd_ir    = fd_valid ? imem_data : NOP_INSN;
    assign fd_pc    = infl_q + 1'b1;

`ifdef FETCH_HALT_EN
    assign halt_hit = fd_valid & fd_en & (fd_ir == HALT_INSN);
    assign halted   = in_halt;
`else
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    assign dbg_state = state_q;

    // Fetch FSM and data-valid flag: fill after reset/redirect, run, halt
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= FETCH_FILL;
            vld_q   <= 1'b0;
        end else if (redirect_valid) begin
            state_q <= FETCH_FILL;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                FETCH_FILL, FETCH_RUN: begin
                    if (halt_hit) begin
                        // Halt word is consumed this cycle (fd_en implies no stall)
                        state_q <= FETCH_HALTED;
                        vld_q   <= 1'b1;
                    end else if (!stall) begin
                        state_q <= FETCH_RUN;
                        vld_q   <= 1'b1;
                    end
                end
                FETCH_HALTED: begin
                    state_q <= FETCH_HALTED;
                end
                default: begin
                    state_q <= FETCH_FILL;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. The reference model tracks, per
// cycle, the next instruction address to be delivered, whether a fill
// bubble is pending and whether fetch is halted; it pushes one expected
// record per cycle and a negedge monitor compares against the DUT.
// Build with +define+FETCH_HALT_EN to exercise the halt feature.
module tb_fetch_stage;

    localparam int AW = 12;
    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    logic          clk;
    logic          clr;
    logic          stall;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic [31:0]   fd_pc;
    logic [31:0]   fd_ir;
    logic          fd_valid;
    logic          fd_en;
    logic          halted;
    logic [1:0]    dbg_state;

    fetch_stage #(.ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .clr            (clr),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .fd_pc          (fd_pc),
        .fd_ir          (fd_ir),
        .fd_valid       (fd_valid),
        .fd_en          (fd_en),
        .halted         (halted),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / memory ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:(1<<AW)-1];

    always @(posedge clk) imem_data <= mem[imem_addr];

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        en;
        logic        valid;
        logic        hlt;
        logic [31:0] ir;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per driven cycle, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (!clr && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("fd_en", {31'd0, fd_en}, {31'd0, e.en});
            chk("fd_valid", {31'd0, fd_valid}, {31'd0, e.valid});
            chk("halted", {31'd0, halted}, {31'd0, e.hlt});
            chk("fd_ir", fd_ir, e.ir);
            if (e.valid) chk("fd_pc", fd_pc, e.pc);
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] m_next;    // address of next instruction to reach F/D
    logic        m_bubble;  // fill bubble pending
    logic        m_halt;    // fetch halted

    // Drive one cycle of inputs, record the expected outputs, advance a cycle
    task automatic step(input logic s, input logic r, input logic [31:0] rpc);
        exp_t        e;
        logic [AW-1:0] idx;
        stall          = s;
        redirect_valid = r;
        redirect_pc    = rpc;
        e.en  = ~s | r;
        e.hlt = m_halt;
        e.valid = 1'b0;
        e.ir  = 32'h0;
        e.pc  = 32'h0;
        if (r) begin
            m_next   = rpc;
            m_bubble = 1'b1;
            m_halt   = 1'b0;
        end else if (m_halt) begin
            e.valid = 1'b0;
        end else if (m_bubble) begin
            if (!s) m_bubble = 1'b0;
        end else begin
            idx     = m_next[AW-1:0];
            e.valid = 1'b1;
            e.ir    = mem[idx];
            e.pc    = m_next + 32'd1;
            if (!s) begin
`ifdef FETCH_HALT_EN
                if (e.ir == HALT_W) m_halt = 1'b1;
`endif
                m_next = m_next + 32'd1;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Assert clr, check outputs react immediately, release after one edge
    task automatic do_reset();
        clr            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        exp_q.delete();
        m_next   = 32'h0;
        m_bubble = 1'b1;
        m_halt   = 1'b0;
        #1;
        chk("rst_fd_valid", {31'd0, fd_valid}, 32'd0);
        chk("rst_fd_ir", fd_ir, 32'h0);
        chk("rst_imem_addr", {20'd0, imem_addr}, 32'h0);
        chk("rst_fd_pc", fd_pc, 32'h1);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = (i < 256) ? (32'd100 + i) : ($urandom & 32'h7FFF_FFFF);
        end
`ifdef FETCH_HALT_EN
        mem[3] = HALT_W;
`endif
        checks = 0;
        errors = 0;
        imem_data = 32'h0;

        do_reset();

        // Straight-line fill then stream, then a 3-cycle stall on mem[5]
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);

        // Redirect to 0x40, without and with a simultaneous stall
        step(1'b0, 1'b1, 32'h40);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h40);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);

        // Address wrap and full PC wrap
        step(1'b0, 1'b1, 32'h0000_0FFF);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);

        // Reset mid-run, then refill from RESET_PC
        step(1'b0, 1'b0, 32'h0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);

`ifdef FETCH_HALT_EN
        // Run into the halt word at 3, sit halted (with stalls), resume at 0x10
        step(1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h10);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
`endif

        // Randomized stall/redirect traffic
        for (int i = 0; i < 400; i++) begin
            logic        s;
            logic        r;
            logic [31:0] t;
            s = ($urandom_range(0, 99) < 30);
            r = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 3) == 0) t = $urandom;
            else                           t = $urandom_range(0, (1 << AW) - 1);
            step(s, r, t);
        end

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog in case something stops the clocked flow
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
